// File: rtl/fifo_flex.sv
// fifo_flex: parametrised synchronous FIFO with occupancy count,
// registered full/empty/almost flags, synchronous flush and sticky
// overflow/underflow error flags. Show-ahead read port: dataout always
// presents the head-of-queue word while the FIFO is non-empty.
//
// Optional feature: define FIFO_FLEX_WATERMARK_EN to add the `peak`
// output, the highest occupancy seen since the last reset or flush.
//
// DEPTH must be a power of two and >= 2 so that the pointers wrap by
// natural AW-bit overflow. AF_THR is legal in 1..DEPTH, AE_THR in
// 0..DEPTH-1.

module fifo_flex #(
  parameter int unsigned  WIDTH  = 8,
  parameter int unsigned  DEPTH  = 4,
  parameter int unsigned  AF_THR = DEPTH - 1,
  parameter int unsigned  AE_THR = 1,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
`ifdef FIFO_FLEX_WATERMARK_EN
  ,
  output logic [AW:0]      peak
`endif
);

  // Thresholds and depth brought to the count width once, so every
  // flag comparison below is a plain same-width unsigned compare.
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_THR_C = (AW+1)'(AF_THR);
  localparam logic [AW:0] AE_THR_C = (AW+1)'(AE_THR);

  // Flag values for an empty FIFO (count == 0); used by reset and flush.
  // almost_full is only set at zero occupancy for an (illegal) AF_THR of 0.
  localparam logic AF_AT_ZERO = (AF_THR_C == '0);
  localparam logic AE_AT_ZERO = 1'b1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  logic full_q,         full_d;
  logic empty_q,        empty_d;
  logic almost_full_q,  almost_full_d;
  logic almost_empty_q, almost_empty_d;
  logic overflow_q,     overflow_d;
  logic underflow_q,    underflow_d;

`ifdef FIFO_FLEX_WATERMARK_EN
  logic [AW:0] peak_q, peak_d;
`endif

  // Accept decisions, taken on pre-edge registered state only.
  logic push_ok;
  logic pop_ok;
  logic wr_en;

  // ---------------------------------------------------------------------
  // Next-state logic: accept rules, pointers, count, error and level flags
  // ---------------------------------------------------------------------
  // A pop is accepted whenever there is data. A push is accepted when there
  // is room, or when a same-cycle accepted pop frees the slot it needs.
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pop_ok  = pop & ~empty_q;
    push_ok = push & (~full_q | pop_ok);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clr) begin
      // Flush wins over any same-cycle traffic; rejected requests in this
      // cycle do not count as errors.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d     = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      overflow_d  = overflow_q  | (push & ~push_ok);
      underflow_d = underflow_q | (pop  & ~pop_ok);
    end

    // Level flags are computed from the next count and registered, so they
    // agree with count in the same cycle and never see push/pop directly.
    full_d         = (count_d == DEPTH_C);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AF_THR_C);
    almost_empty_d = (count_d <= AE_THR_C);
  end

`ifdef FIFO_FLEX_WATERMARK_EN
  // High-water mark tracks the largest next-count since reset/flush.
  always_comb begin
    peak_d = peak_q;
    if (clr) begin
      peak_d = '0;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end
  end
`endif

  // Storage is written only for accepted, non-flushed pushes.
  assign wr_en = push_ok & ~clr;

  // ---------------------------------------------------------------------
  // Control/status registers with asynchronous reset
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= AF_AT_ZERO;
      almost_empty_q <= AE_AT_ZERO;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

`ifdef FIFO_FLEX_WATERMARK_EN
  // High-water mark register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------
  // NOTE: the data array has no reset; its contents are only observable
  // through dataout while the FIFO is non-empty, and every such word has
  // been written first. Leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= datain;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // Show-ahead read: head word straight from registered state.
  assign dataout      = mem_q[rd_ptr_q];
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
`ifdef FIFO_FLEX_WATERMARK_EN
  assign peak         = peak_q;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex (DEPTH=4, WIDTH=8, AF_THR=3, AE_THR=1).
// A queue-based reference model follows the accept rules at transaction
// level; one compare process checks every output against it on each
// falling edge, and directed literal checks pin the model to the test plan.

module tb_fifo_flex;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;
  logic             full, empty, almost_full, almost_empty;
  logic [2:0]       count;
  logic             overflow, underflow;
`ifdef FIFO_FLEX_WATERMARK_EN
  logic [2:0]       peak;
`endif

  fifo_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THR(AF), .AE_THR(AE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .push         (push),
    .pop          (pop),
    .datain       (datain),
    .dataout      (dataout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
`ifdef FIFO_FLEX_WATERMARK_EN
    ,
    .peak         (peak)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf;
  bit               m_unf;
  int               m_peak;
  bit               chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_peak = 0;
  endtask

  task automatic model_step(input bit p, input bit po, input logic [WIDTH-1:0] d, input bit c);
    bit pop_ok, push_ok;
    if (c) begin
      model_reset();
      return;
    end
    pop_ok  = po && (mq.size() > 0);
    push_ok = p && ((mq.size() < DEPTH) || pop_ok);
    if (p && !push_ok) m_ovf = 1'b1;
    if (po && !pop_ok) m_unf = 1'b1;
    if (pop_ok) void'(mq.pop_front());
    if (push_ok) mq.push_back(d);
    if (mq.size() > m_peak) m_peak = mq.size();
  endtask

  // Called at a falling edge: apply inputs, clock once, advance the model,
  // return at the next falling edge.
  task automatic drive(input bit p, input bit po, input logic [WIDTH-1:0] d, input bit c);
    push   = p;
    pop    = po;
    datain = d;
    clr    = c;
    @(posedge clk);
    model_step(p, po, d, c);
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
    clr  = 1'b0;
  endtask

  // Compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = mq.size();
      check("count",        32'(count),        32'(n));
      check("empty",        32'(empty),        32'(n == 0));
      check("full",         32'(full),         32'(n == DEPTH));
      check("almost_full",  32'(almost_full),  32'(n >= AF));
      check("almost_empty", 32'(almost_empty), 32'(n <= AE));
      check("overflow",     32'(overflow),     32'(m_ovf));
      check("underflow",    32'(underflow),    32'(m_unf));
      if (n > 0) check("dataout", 32'(dataout), 32'(mq[0]));
`ifdef FIFO_FLEX_WATERMARK_EN
      check("peak", 32'(peak), 32'(m_peak));
`endif
    end
  end

  // Watchdog: the run is bounded by the clock, but never allow a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    clr    = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    datain = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Reset state
    check("rst_count", 32'(count), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full",  32'(full),  32'h0);
    check("rst_ae",    32'(almost_empty), 32'h1);
    check("rst_af",    32'(almost_full),  32'h0);

    // Fill 0x11..0x44
    drive(1, 0, 8'h11, 0);
    check("f1_count", 32'(count), 32'h1);
    check("f1_ae",    32'(almost_empty), 32'h1);
    check("f1_dout",  32'(dataout), 32'h11);
    drive(1, 0, 8'h22, 0);
    check("f2_count", 32'(count), 32'h2);
    check("f2_ae",    32'(almost_empty), 32'h0);
    check("f2_af",    32'(almost_full),  32'h0);
    drive(1, 0, 8'h33, 0);
    check("f3_count", 32'(count), 32'h3);
    check("f3_af",    32'(almost_full), 32'h1);
    check("f3_full",  32'(full), 32'h0);
    drive(1, 0, 8'h44, 0);
    check("f4_count", 32'(count), 32'h4);
    check("f4_full",  32'(full), 32'h1);
    check("f4_dout",  32'(dataout), 32'h11);
    check("f4_ovf",   32'(overflow), 32'h0);
`ifdef FIFO_FLEX_WATERMARK_EN
    check("f4_peak",  32'(peak), 32'h4);
`endif

    // Push when full is rejected and sets sticky overflow
    drive(1, 0, 8'h55, 0);
    check("ovf_count", 32'(count), 32'h4);
    check("ovf_flag",  32'(overflow), 32'h1);

    // Drain in order
    check("pop0_dout", 32'(dataout), 32'h11);
    drive(0, 1, 8'h00, 0);
    check("pop1_dout", 32'(dataout), 32'h22);
    drive(0, 1, 8'h00, 0);
    check("pop2_dout", 32'(dataout), 32'h33);
    drive(0, 1, 8'h00, 0);
    check("pop3_dout", 32'(dataout), 32'h44);
    drive(0, 1, 8'h00, 0);
    check("drain_empty", 32'(empty), 32'h1);
    check("drain_ovf",   32'(overflow), 32'h1);

    // Flush, then push+pop on empty: push wins, pop is an underflow
    drive(0, 0, 8'h00, 1);
    drive(1, 1, 8'hA5, 0);
    check("pe_count", 32'(count), 32'h1);
    check("pe_dout",  32'(dataout), 32'hA5);
    check("pe_unf",   32'(underflow), 32'h1);
    check("pe_empty", 32'(empty), 32'h0);

    // Flush, fill, then push+pop while full for 6 cycles (pointer wrap)
    drive(0, 0, 8'h00, 1);
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 8'h61 + 8'(i), 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 8'h66 + 8'(i), 0);
      check("pp_count", 32'(count), 32'h4);
      check("pp_full",  32'(full), 32'h1);
      check("pp_ovf",   32'(overflow), 32'h0);
    end
    // Six pops removed 0x61..0x64,0x66,0x67; head is now 0x68
    check("pp_head", 32'(dataout), 32'h68);
    for (int i = 0; i < DEPTH; i++) drive(0, 1, 8'h00, 0);
    check("pp_empty", 32'(empty), 32'h1);

    // Count 3 with overflow set, then clr together with push
    for (int i = 0; i < DEPTH + 1; i++) drive(1, 0, 8'h70 + 8'(i), 0);
    drive(0, 1, 8'h00, 0);
    check("pre_clr_count", 32'(count), 32'h3);
    check("pre_clr_ovf",   32'(overflow), 32'h1);
    drive(1, 0, 8'h99, 1);
    check("clr_count", 32'(count), 32'h0);
    check("clr_empty", 32'(empty), 32'h1);
    check("clr_ovf",   32'(overflow), 32'h0);
    check("clr_unf",   32'(underflow), 32'h0);
`ifdef FIFO_FLEX_WATERMARK_EN
    check("clr_peak",  32'(peak), 32'h0);
`endif

    // Asynchronous reset mid-cycle with count 2
    drive(1, 0, 8'hC1, 0);
    drive(1, 0, 8'hC2, 0);
    check("ar_pre_count", 32'(count), 32'h2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar_count", 32'(count), 32'h0);
    check("ar_empty", 32'(empty), 32'h1);
    check("ar_ae",    32'(almost_empty), 32'h1);
    check("ar_af",    32'(almost_full),  32'h0);
    check("ar_full",  32'(full), 32'h0);
`ifdef FIFO_FLEX_WATERMARK_EN
    check("ar_peak",  32'(peak), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 8'hD1, 0);
    check("post_rst_dout", 32'(dataout), 32'hD1);
    drive(0, 0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
